// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 3-digit 7-segment display and reassembles the shown number.
// Each digit slot is captured once per stable dwell; a full H/T/O frame yields one 8-bit value.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic [3:0] dig_n,
    output logic [7:0] value,
    output logic       value_valid,
    input  logic       value_ready,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        WAIT_H = 2'd0,
        GOT_H  = 2'd1,
        GOT_T  = 2'd2
    } state_t;

    localparam logic [1:0] SLOT_H    = 2'd0;
    localparam logic [1:0] SLOT_T    = 2'd1;
    localparam logic [1:0] SLOT_O    = 2'd2;
    localparam logic [1:0] SLOT_NONE = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_PRE  = 8'(STABLE_CYCLES - 2);

    // {valid, digit}; valid=0 for any pattern that is not a decimal digit
    function automatic logic [4:0] seg_to_bcd(input logic [6:0] s);
        case (s)
            7'b1111110: return 5'h10;
            7'b0110000: return 5'h11;
            7'b1101101: return 5'h12;
            7'b1111001: return 5'h13;
            7'b0110011: return 5'h14;
            7'b1011011: return 5'h15;
            7'b1011111: return 5'h16;
            7'b1110000: return 5'h17;
            7'b1111111: return 5'h18;
            7'b1110011: return 5'h19;
            default:    return 5'h00;
        endcase
    endfunction

    logic [6:0]  seg_s1_reg, seg_s2_reg;
    logic [3:0]  dig_s1_reg, dig_s2_reg;
    logic [10:0] prev_reg;
    logic [7:0]  count_reg;
    logic        cap_reg;
    logic [1:0]  cap_slot_reg;
    logic [6:0]  cap_seg_reg;
    logic [3:0]  h_reg, t_reg;
    state_t      state_reg, state_next;

    logic        same;
    logic [1:0]  slot;
    logic        cap_next;
    logic [4:0]  cap_bcd;
    logic        cap_valid;
    logic [3:0]  cap_digit;
    logic        store_h, store_t, seq_err, complete;
    logic [9:0]  frame_sum;
    logic        good;
    logic        err_evt;

    assign same     = ({dig_s2_reg, seg_s2_reg} == prev_reg);
    assign cap_next = same && (count_reg == CNT_PRE) && (slot != SLOT_NONE);

    always_comb begin
        slot = SLOT_NONE;
        case (dig_s2_reg)
            4'b1011: slot = SLOT_H;
            4'b1101: slot = SLOT_T;
            4'b1110: slot = SLOT_O;
            default: slot = SLOT_NONE;
        endcase
    end

    // Synchronizer, stability counter and one-shot capture register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_reg   <= 7'h00;
            seg_s2_reg   <= 7'h00;
            dig_s1_reg   <= 4'hF;
            dig_s2_reg   <= 4'hF;
            prev_reg     <= {4'hF, 7'h00};
            count_reg    <= 8'd0;
            cap_reg      <= 1'b0;
            cap_slot_reg <= SLOT_NONE;
            cap_seg_reg  <= 7'h00;
        end else begin
            seg_s1_reg <= seg_in;
            seg_s2_reg <= seg_s1_reg;
            dig_s1_reg <= dig_n;
            dig_s2_reg <= dig_s1_reg;
            prev_reg   <= {dig_s2_reg, seg_s2_reg};
            if (!same) begin
                count_reg <= 8'd0;
            end else if (count_reg != CNT_LAST) begin
                count_reg <= count_reg + 8'd1;
            end
            cap_reg <= cap_next;
            if (cap_next) begin
                cap_slot_reg <= slot;
                cap_seg_reg  <= seg_s2_reg;
            end
        end
    end

    assign cap_bcd   = seg_to_bcd(cap_seg_reg);
    assign cap_valid = cap_bcd[4];
    assign cap_digit = cap_bcd[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= WAIT_H;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cap_reg) begin
            if (!cap_valid) begin
                state_next = WAIT_H;
            end else begin
                case (state_reg)
                    WAIT_H: if (cap_slot_reg == SLOT_H) state_next = GOT_H;
                    GOT_H: begin
                        if (cap_slot_reg == SLOT_T)      state_next = GOT_T;
                        else if (cap_slot_reg == SLOT_O) state_next = WAIT_H;
                    end
                    GOT_T:   state_next = WAIT_H;
                    default: state_next = WAIT_H;
                endcase
            end
        end
    end

    always_comb begin
        store_h  = 1'b0;
        store_t  = 1'b0;
        seq_err  = 1'b0;
        complete = 1'b0;
        if (cap_reg) begin
            if (!cap_valid) begin
                seq_err = 1'b1;
            end else begin
                case (state_reg)
                    WAIT_H: store_h = (cap_slot_reg == SLOT_H);
                    GOT_H: begin
                        store_h = (cap_slot_reg == SLOT_H);
                        store_t = (cap_slot_reg == SLOT_T);
                        seq_err = (cap_slot_reg == SLOT_O);
                    end
                    GOT_T: begin
                        complete = (cap_slot_reg == SLOT_O);
                        seq_err  = (cap_slot_reg != SLOT_O);
                    end
                    default: seq_err = 1'b1;
                endcase
            end
        end
    end

    // 999 is the largest possible sum, so 10 bits never overflow
    assign frame_sum = 10'(h_reg) * 10'd100 + 10'(t_reg) * 10'd10 + 10'(cap_digit);
    assign good      = complete && (frame_sum <= 10'd255);
    assign err_evt   = seq_err || (complete && !good);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_reg       <= 4'd0;
            t_reg       <= 4'd0;
            value       <= 8'h00;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (store_h) h_reg <= cap_digit;
            if (store_t) t_reg <= cap_digit;
            frame_err <= err_evt;
            overrun   <= good && value_valid && !value_ready;
            if (good && (!value_valid || value_ready)) begin
                value       <= frame_sum[7:0];
                value_valid <= 1'b1;
            end else if (value_valid && value_ready) begin
                value_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each frame pushes its expected event,
// a negedge monitor pops and compares whenever the DUT emits a value, error or overrun.
module tb_seg_scan_decoder;

    localparam int S = 4;
    localparam logic [3:0] DIG_H = 4'b1011;
    localparam logic [3:0] DIG_T = 4'b1101;
    localparam logic [3:0] DIG_O = 4'b1110;
    localparam int EV_NONE = 0;
    localparam int EV_VAL  = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_OVR  = 3;

    typedef struct {
        int kind;
        int val;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] dig_n = 4'hF;
    logic       value_ready = 1'b0;
    logic [7:0] value;
    logic       value_valid;
    logic       frame_err;
    logic       overrun;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_vv = 0;
    evt_t sb_q[$];
    logic rdy_e = 1'b0;
    logic vv_d = 1'b0;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_n       (dig_n),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic note_evt(input int kind, input int val);
        evt_t e;
        if (sb_q.size() == 0) begin
            e.kind = EV_NONE;
            e.val  = 0;
        end else begin
            e = sb_q.pop_front();
        end
        check("evt_kind", kind, e.kind);
        if (kind == EV_VAL && e.kind == EV_VAL) check("evt_value", val, e.val);
        $display("[%0t] event kind=%0d value=%0d", $time, kind, val);
    endtask

    task automatic push(input int kind, input int val);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    // ready level at the edge, so handshakes are seen exactly as the DUT saw them
    always @(posedge clk) rdy_e <= value_ready;

    always @(negedge clk) begin
        if (!rst_n) begin
            vv_d <= 1'b0;
        end else begin
            if (frame_err || overrun) check("fe_ov_excl", {31'b0, frame_err & overrun}, 0);
            if (frame_err) note_evt(EV_ERR, 0);
            if (overrun) note_evt(EV_OVR, 0);
            if (value_valid && (!vv_d || rdy_e)) note_evt(EV_VAL, int'(value));
            vv_d <= value_valid;
        end
    end

    task automatic put(input logic [3:0] d, input logic [6:0] s, input int n);
        @(negedge clk);
        #1;
        dig_n  = d;
        seg_in = s;
        repeat (n) @(posedge clk);
    endtask

    task automatic gap();
        put(4'hF, 7'h00, 3);
    endtask

    task automatic head(input int h, input int t);
        put(DIG_H, seg_tab[h], 8);
        gap();
        put(DIG_T, seg_tab[t], 8);
        gap();
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("sb_drain", sb_q.size(), 0);
    endtask

    task automatic expect_frame(input int h, input int t, input int o);
        int sum = h * 100 + t * 10 + o;
        if (sum > 255) begin
            push(EV_ERR, 0);
        end else if (exp_vv != 0) begin
            push(EV_OVR, 0);
        end else begin
            push(EV_VAL, sum);
            exp_vv = 1;
        end
    endtask

    task automatic frame(input int h, input int t, input int o);
        expect_frame(h, t, o);
        head(h, t);
        put(DIG_O, seg_tab[o], 8);
        gap();
        drain();
        $display("[%0t] frame %0d%0d%0d value=%0d valid=%0b", $time, h, t, o, value, value_valid);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        #1;
        value_ready = 1'b1;
        @(negedge clk);
        #1;
        value_ready = 1'b0;
        exp_vv = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // 1,4,4 -> 0x90 with exact latency from the ones dwell start
        push(EV_VAL, 144);
        exp_vv = 1;
        head(1, 4);
        @(negedge clk);
        #1;
        dig_n  = DIG_O;
        seg_in = seg_tab[4];
        repeat (S + 2) @(posedge clk);
        #1;
        check("lat_before", value_valid, 0);
        @(posedge clk);
        #1;
        check("lat_after", value_valid, 1);
        check("val_90", value, 8'h90);
        repeat (4) @(posedge clk);
        gap();
        drain();
        pulse_ready();
        @(negedge clk);
        check("vv_cleared", value_valid, 0);
        check("val_kept", value, 8'h90);

        // 256 overflows
        frame(2, 5, 6);
        check("ovf_vv", value_valid, 0);
        check("ovf_val", value, 8'h90);

        // tens dwell one cycle short: never captured, ones then arrives in GOT_H
        push(EV_ERR, 0);
        put(DIG_H, seg_tab[1], 8);
        gap();
        put(DIG_T, seg_tab[2], S - 1);
        gap();
        put(DIG_O, seg_tab[3], 8);
        gap();
        drain();
        check("short_vv", value_valid, 0);

        // overrun while holding 0x2A
        frame(0, 4, 2);
        frame(0, 0, 7);
        check("ovr_val", value, 8'h2A);
        check("ovr_vv", value_valid, 1);
        pulse_ready();
        @(negedge clk);
        check("ovr_vv_clr", value_valid, 0);

        // invalid segments in the hundreds slot, then a good frame
        push(EV_ERR, 0);
        put(DIG_H, 7'b0000001, 8);
        gap();
        drain();
        frame(0, 0, 9);
        check("val_09", value, 8'h09);

        // completion coinciding with a handshake, at the 255 boundary
        push(EV_VAL, 255);
        head(2, 5);
        @(negedge clk);
        #1;
        dig_n  = DIG_O;
        seg_in = seg_tab[5];
        repeat (S + 2) @(posedge clk);
        #1;
        value_ready = 1'b1;
        @(posedge clk);
        #1;
        value_ready = 1'b0;
        check("hs_vv", value_valid, 1);
        check("hs_val", value, 8'hFF);
        gap();
        drain();

        // reset while in GOT_T
        head(1, 2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_value", value, 0);
        check("rst2_valid", value_valid, 0);
        check("rst2_ferr", frame_err, 0);
        check("rst2_ovr", overrun, 0);
        #1;
        rst_n  = 1'b1;
        exp_vv = 0;
        frame(1, 2, 3);
        check("val_7b", value, 8'h7B);
        check("val_7b_vv", value_valid, 1);

        repeat (5) @(negedge clk);
        check("sb_final", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
